// File: rtl/name_tx_pkg.sv
// Shared constants for the name_tx character stream source: FSM encoding,
// default idle/delimiter characters and width helpers.
package name_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_TRAIL = 2'd2;

  localparam logic [7:0] DEF_IDLE_CHAR  = 8'h20;
  localparam logic [7:0] DEF_DELIM_CHAR = 8'h2E;

  // count must hold the value DEPTH itself, hence DEPTH+1 codes
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/name_tx_buf.sv
// Character buffer for name_tx: DEPTH x 8 register file filled in order,
// with occupancy count, full flag, synchronous clear and a combinational read port.
module name_tx_buf
  import name_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic [cnt_width(DEPTH)-1:0] rd_idx,
  output logic [7:0]                  rd_data,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = addr_width(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] count_reg;
  logic          wr_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign wr_ok = wr_en && !full && !clr;
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (wr_ok) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Storage carries no reset; only slots below count are ever read out.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count_reg[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < CW'(DEPTH)) ? mem[rd_idx[AW-1:0]] : 8'h00;

endmodule

// File: rtl/name_tx.sv
// name_tx: buffers a string, then emits it one character per clock on `name`.
// Define NAME_TX_DELIM_EN to append DELIM_CHAR after the last character.
module name_tx
  import name_tx_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] IDLE_CHAR  = DEF_IDLE_CHAR,
  parameter logic [7:0] DELIM_CHAR = DEF_DELIM_CHAR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        start,
  output logic [7:0]                  name,
  output logic                        name_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] idx_reg, idx_next;
  logic [7:0]    name_reg, name_next;
  logic          name_valid_reg, name_valid_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          end_seq;
  logic          launch;
  logic          buf_wr;
  logic [7:0]    rd_data;

  assign launch = (state_reg == ST_IDLE) && start && (count != '0);
  // A start that launches a stream takes precedence over a same-cycle write.
  assign buf_wr = (state_reg == ST_IDLE) && wr_en && !launch;

  name_tx_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .clr    (end_seq),
    .wr_en  (buf_wr),
    .wr_data(wr_data),
    .rd_idx (idx_reg),
    .rd_data(rd_data),
    .full   (full),
    .count  (count)
  );

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    name_next       = name_reg;
    name_valid_next = name_valid_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    end_seq         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        name_next       = IDLE_CHAR;
        name_valid_next = 1'b0;
        busy_next       = 1'b0;
        // idx rests at 0 in IDLE, so rd_data already presents slot 0
        if (launch) begin
          state_next      = ST_SEND;
          name_next       = rd_data;
          name_valid_next = 1'b1;
          busy_next       = 1'b1;
          idx_next        = CW'(1);
        end
      end
      ST_SEND: begin
        if (idx_reg < count) begin
          name_next = rd_data;
          idx_next  = idx_reg + CW'(1);
        end else begin
`ifdef NAME_TX_DELIM_EN
          state_next = ST_TRAIL;
          name_next  = DELIM_CHAR;
`else
          end_seq = 1'b1;
`endif
        end
      end
`ifdef NAME_TX_DELIM_EN
      ST_TRAIL: end_seq = 1'b1;
`endif
      default: end_seq = 1'b1;
    endcase

    if (end_seq) begin
      state_next      = ST_IDLE;
      idx_next        = '0;
      name_next       = IDLE_CHAR;
      name_valid_next = 1'b0;
      busy_next       = 1'b0;
      done_next       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      name_reg       <= IDLE_CHAR;
      name_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      name_reg       <= name_next;
      name_valid_reg <= name_valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign name       = name_reg;
  assign name_valid = name_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: doc/name_tx.md
Name: name_tx

Overview:
- Serial ASCII character transmitter that drives a one-character-per-clock `name` stream, the same format the username recogniser consumes.
- Upstream logic loads a string into an internal buffer; a `start` pulse then emits the buffered characters back-to-back, one per cycle.
- Used as the stream source in front of the recogniser, both on-chip and in benches.

Parameters:
- DEPTH, 16, maximum characters buffered (>=1).
- IDLE_CHAR, 8'h20, value driven on `name` while no character is being sent (ASCII space).
- DELIM_CHAR, 8'h2E, trailer character used by the optional feature (ASCII '.').

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write `wr_data` into the buffer at the next free slot.
- wr_data  in  8  ASCII character to buffer.
- start  in  1  begin transmitting the buffer contents.
- name  out  8  current stream character (registered).
- name_valid  out  1  `name` carries a transmitted character this cycle.
- busy  out  1  transmission in progress; writes and start are ignored.
- done  out  1  one-cycle pulse once the stream has ended.
- full  out  1  buffer count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of characters currently buffered.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values: name=IDLE_CHAR, name_valid=0, busy=0, done=0, count=0, full=0, state=IDLE, idx=0. Buffer contents are don't-care.
- Reset mid-transmission: aborts at that edge, no done pulse, and the buffer is cleared.
- States: IDLE, SEND, plus TRAIL when NAME_TX_DELIM_EN is defined.
- IDLE, write:
  - wr_en && !full: buf[count]<=wr_data, count++.
  - wr_en while full: dropped, count unchanged.
- IDLE, start:
  - start && count>0: go to SEND, name<=buf[0], name_valid<=1, busy<=1, idx<=1.
  - First character appears in the cycle after start is sampled (latency 1).
  - start && wr_en in the same IDLE cycle with count>0: start wins and the write is dropped.
  - start with count==0: ignored. A write in that cycle is still accepted.
- SEND:
  - Each edge with idx<count: name<=buf[idx], idx++, name_valid stays 1.
  - Edge with idx==count: name<=IDLE_CHAR, name_valid<=0, busy<=0, done<=1, count<=0, state<=IDLE.
  - Exactly `count` consecutive name_valid cycles, no gaps.
- done: high exactly one cycle, coincident with the first idle cycle. A new start may be sampled in that same cycle, but count is 0 then, so it is ignored.
- Inputs while busy: wr_en and start are ignored.
- Arithmetic: count and idx are unsigned. count never exceeds DEPTH and idx never exceeds count, so neither wraps.

Optional Feature:
- Macro: NAME_TX_DELIM_EN.
- Defined: after the last buffered character, the edge with idx==count goes to TRAIL with name<=DELIM_CHAR and name_valid<=1. The next edge performs the normal end sequence (name=IDLE_CHAR, done=1).
  - Stream length is count+1 and busy lasts count+1 cycles.
- Undefined: no TRAIL state exists; the stream ends directly after the last character.

Decomposition:
- Package name_tx_pkg: state encoding (IDLE/SEND/TRAIL), default IDLE_CHAR and DELIM_CHAR constants, and a count-width helper.
- Sub-module name_tx_buf: DEPTH x 8 register file with write pointer, count and full flag, a synchronous clear input, and an index-addressed combinational read port.
- Top module: FSM and output registers.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, then 0 -> name=8'h20, name_valid=0, busy=0, done=0, count=0.
- Basic send: write "s","2","w" (0x73,0x32,0x77), pulse start -> name_valid high 3 consecutive cycles carrying 0x73,0x32,0x77; then name=0x20, done=1 for 1 cycle; count=0.
- Full and overflow: with DEPTH=4, write 5 chars "trz.2" -> full=1, count=4. Start -> stream "trz." and the fifth character never appears.
- Ignored inputs: during SEND, assert wr_en with "x" and start -> no change to the stream, and count=0 after done. Start with an empty buffer -> name_valid stays 0 and no done pulse.
- Reset mid-send: write "abcd", start, assert reset on the 2nd valid cycle -> next cycle all outputs at reset values, no done, count=0.
- Delimiter (NAME_TX_DELIM_EN): write "22", start -> valid stream 0x32,0x32,0x2E, then done. Without the macro -> 0x32,0x32 only.
